// File: rtl/lsu_mem_seq_if.sv
// Bundle of the load/store request, response and single-port RAM signals.
// master = pipeline plus RAM side; slave = the sequencer.
interface lsu_mem_seq_if #(
  parameter int ADDR_W = 8
);
  logic              req;
  logic              we;
  logic [2:0]        func3;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              ready;
  logic              done;
  logic              err;
  logic [31:0]       rdata;
  logic              ram_ce;
  logic              ram_rd;
  logic              ram_wr;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_rdata;
  logic [31:0]       ram_wdata;

  modport master (
    output req, we, func3, addr, wdata, ram_rdata,
    input  ready, done, err, rdata, ram_ce, ram_rd, ram_wr, ram_addr, ram_wdata
  );

  modport slave (
    input  req, we, func3, addr, wdata, ram_rdata,
    output ready, done, err, rdata, ram_ce, ram_rd, ram_wr, ram_addr, ram_wdata
  );
endinterface

// File: rtl/lsu_mem_seq.sv
// RV32I load/store sequencer for a word-wide single-port RAM with one-cycle read
// latency; sub-word stores are done as read-modify-write.
module lsu_mem_seq #(
  parameter int ADDR_W = 8
) (
  input logic          clk,
  input logic          rst_n,
  lsu_mem_seq_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t            state_reg, state_next;
  logic              we_reg;
  logic [2:0]        func3_reg;
  logic [1:0]        lane_reg;
  logic [ADDR_W-1:0] waddr_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       rdata_reg;

  logic              fault;
  logic [3:0]        be;
  logic [31:0]       wide;
  logic [31:0]       merged;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic [31:0]       load_val;
  logic              unused_addr_hi;

  // Upper address bits only select beyond the RAM, so they wrap silently.
  assign unused_addr_hi = ^bus.addr[31:ADDR_W+2];

  always_comb begin
    fault = 1'b0;
    if (bus.we)
      fault = (bus.func3 > 3'd2);
    else
      fault = (bus.func3 == 3'd3) || (bus.func3 > 3'd5);
    if ((bus.func3[1:0] == 2'd1) && bus.addr[0])
      fault = 1'b1;
    if ((bus.func3 == 3'd2) && (bus.addr[1:0] != 2'd0))
      fault = 1'b1;
  end

  // Store data replicated across lanes; byte enables pick which lanes take it.
  always_comb begin
    be   = 4'hF;
    wide = wdata_reg;
    case (func3_reg[1:0])
      2'd0: begin
        be   = 4'b0001 << lane_reg;
        wide = {4{wdata_reg[7:0]}};
      end
      2'd1: begin
        be   = lane_reg[1] ? 4'b1100 : 4'b0011;
        wide = {2{wdata_reg[15:0]}};
      end
      default: ;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign merged[8*gi +: 8] = be[gi] ? wide[8*gi +: 8] : bus.ram_rdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    case (lane_reg)
      2'd0:    sel_byte = bus.ram_rdata[7:0];
      2'd1:    sel_byte = bus.ram_rdata[15:8];
      2'd2:    sel_byte = bus.ram_rdata[23:16];
      default: sel_byte = bus.ram_rdata[31:24];
    endcase
    sel_half = lane_reg[1] ? bus.ram_rdata[31:16] : bus.ram_rdata[15:0];
    case (func3_reg)
      3'd0:    load_val = {{24{sel_byte[7]}}, sel_byte};
      3'd4:    load_val = {24'd0, sel_byte};
      3'd1:    load_val = {{16{sel_half[15]}}, sel_half};
      3'd5:    load_val = {16'd0, sel_half};
      default: load_val = bus.ram_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_reg    <= 1'b0;
      func3_reg <= 3'd0;
      lane_reg  <= 2'd0;
      waddr_reg <= '0;
      wdata_reg <= 32'd0;
      rdata_reg <= 32'd0;
    end else begin
      if (state_reg == S_IDLE && bus.req) begin
        we_reg    <= bus.we;
        func3_reg <= bus.func3;
        lane_reg  <= bus.addr[1:0];
        waddr_reg <= bus.addr[ADDR_W+1:2];
        wdata_reg <= bus.wdata;
      end
      // Stores keep the merged word in wdata_reg for the WR cycle.
      if (state_reg == S_CAP) begin
        if (we_reg)
          wdata_reg <= merged;
        else
          rdata_reg <= load_val;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (bus.req) begin
          if (fault)
            state_next = S_ERR;
          else if (bus.we && (bus.func3 == 3'd2))
            state_next = S_WR;
          else
            state_next = S_RD;
        end
      end
      S_RD:    state_next = S_CAP;
      S_CAP:   state_next = we_reg ? S_WR : S_DONE;
      S_WR:    state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      S_ERR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ready     = 1'b0;
    bus.done      = 1'b0;
    bus.err       = 1'b0;
    bus.ram_ce    = 1'b0;
    bus.ram_rd    = 1'b0;
    bus.ram_wr    = 1'b0;
    bus.ram_wdata = 32'd0;
    case (state_reg)
      S_IDLE: bus.ready = 1'b1;
      S_RD: begin
        bus.ram_ce = 1'b1;
        bus.ram_rd = 1'b1;
      end
      S_WR: begin
        bus.ram_ce    = 1'b1;
        bus.ram_wr    = 1'b1;
        bus.ram_wdata = wdata_reg;
      end
      S_DONE: bus.done = 1'b1;
      S_ERR: begin
        bus.done = 1'b1;
        bus.err  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.ram_addr = waddr_reg;
  assign bus.rdata    = rdata_reg;
endmodule

// File: tb/tb_lsu_mem_seq.sv
// Self-checking bench for lsu_mem_seq: directed vector table, reset/handshake
// sequences, then random traffic against a byte-addressed memory model.
module tb_lsu_mem_seq;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  lsu_mem_seq_if #(.ADDR_W(AW)) bus ();
  lsu_mem_seq #(.ADDR_W(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // RAM model: one-cycle read latency; preload port used only while the DUT is idle.
  logic [31:0]   ram [0:(1<<AW)-1];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_idx = '0;
  logic [31:0]   pl_val = 32'd0;
  int            wr_total = 0;
  int            done_total = 0;

  always @(posedge clk) begin
    if (pl_en) ram[pl_idx] <= pl_val;
    if (bus.ram_ce && bus.ram_rd) bus.ram_rdata <= ram[bus.ram_addr];
    if (bus.ram_ce && bus.ram_wr) ram[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_wr) wr_total <= wr_total + 1;
    if (bus.done) done_total <= done_total + 1;
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pre;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[12];
  logic [7:0] refb [0:4*(1<<AW)-1];

  function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] pre, logic e, int lat, logic [31:0] rd, logic [31:0] wd);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.pre = pre;
    v.exp_err = e; v.exp_lat = lat; v.exp_rdata = rd; v.exp_word = wd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] idx, input logic [31:0] val);
    pl_idx = idx; pl_val = val; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Issue one request and follow it to oDONE; counts strobes and illegal strobe combos.
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output logic e,
                        output int nrd, output int nwr, output int bad);
    int n = 0;
    while (!bus.ready && n < 20) begin @(posedge clk); #1; n++; end
    bus.req = 1'b1; bus.we = we; bus.func3 = f3; bus.addr = addr; bus.wdata = wdata;
    @(posedge clk); #1;
    bus.req = 1'b0;
    lat = 99; e = 1'b0; nrd = 0; nwr = 0; bad = 0;
    for (int k = 1; k <= 12; k++) begin
      if (bus.ram_rd) nrd++;
      if (bus.ram_wr) nwr++;
      if (bus.ram_rd && bus.ram_wr) bad++;
      if (!bus.ram_ce && (bus.ram_rd || bus.ram_wr || bus.ram_wdata != 32'd0)) bad++;
      if (bus.ready) bad++;
      if (bus.done) begin lat = k; e = bus.err; break; end
      @(posedge clk); #1;
    end
    $display("op we=%0d f3=%0d addr=%h wdata=%h lat=%0d err=%0d rdata=%h",
             we, f3, addr, wdata, lat, e, bus.rdata);
  endtask

  function automatic logic mdl_fault(logic we, logic [2:0] f3, logic [31:0] a);
    logic f;
    if (we) f = (f3 > 3'd2);
    else    f = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) f = 1'b1;
    if (f3 == 3'd2 && a[1:0] != 2'd0) f = 1'b1;
    return f;
  endfunction

  function automatic logic [31:0] ref_word(int w);
    return {refb[4*w+3], refb[4*w+2], refb[4*w+1], refb[4*w]};
  endfunction

  initial begin
    int          lat, nrd, nwr, bad, w, base, wr0, dn0, issued, ndone;
    logic        e, we, fl;
    logic [2:0]  f3;
    logic [31:0] a, d, v, ref_rdata, exp_rd;
    logic [31:0] hd [3];
    logic [2:0]  f3s [5];

    bus.req = 1'b0; bus.we = 1'b0; bus.func3 = 3'd0; bus.addr = 32'd0; bus.wdata = 32'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_ce", 32'(bus.ram_ce), 32'd0);
    check("rst_rd_wr", 32'({bus.ram_rd, bus.ram_wr}), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    check("rst_ram_wdata", bus.ram_wdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    vecs[0]  = mk(1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 32'h0, 32'hDEADBEEF);
    vecs[1]  = mk(1, 3'd0, 32'h0D, 32'h000000AA, 32'h11223344, 0, 4, 32'h0, 32'h1122AA44);
    vecs[2]  = mk(0, 3'd0, 32'h03, 32'h0, 32'h80F07F01, 0, 3, 32'hFFFFFF80, 32'h80F07F01);
    vecs[3]  = mk(0, 3'd4, 32'h03, 32'h0, 32'h80F07F01, 0, 3, 32'h00000080, 32'h80F07F01);
    vecs[4]  = mk(0, 3'd1, 32'h02, 32'h0, 32'h80F07F01, 0, 3, 32'hFFFF80F0, 32'h80F07F01);
    vecs[5]  = mk(0, 3'd5, 32'h00, 32'h0, 32'h80F07F01, 0, 3, 32'h00007F01, 32'h80F07F01);
    vecs[6]  = mk(0, 3'd2, 32'h06, 32'h0, 32'h12345678, 1, 1, 32'h00007F01, 32'h12345678);
    vecs[7]  = mk(1, 3'd1, 32'h01, 32'hFFFF, 32'h55AA55AA, 1, 1, 32'h00007F01, 32'h55AA55AA);
    vecs[8]  = mk(1, 3'd1, 32'h402, 32'h1234BEEF, 32'hCAFEF00D, 0, 4, 32'h00007F01, 32'hBEEFF00D);
    vecs[9]  = mk(0, 3'd2, 32'hFFFFFC00, 32'h0, 32'hA5A55A5A, 0, 3, 32'hA5A55A5A, 32'hA5A55A5A);
    vecs[10] = mk(0, 3'd3, 32'h20, 32'h0, 32'h0, 1, 1, 32'hA5A55A5A, 32'h0);
    vecs[11] = mk(1, 3'd4, 32'h24, 32'h99, 32'h77, 1, 1, 32'hA5A55A5A, 32'h77);

    for (int i = 0; i < 12; i++) begin
      preload(vecs[i].addr[AW+1:2], vecs[i].pre);
      run_op(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, lat, e, nrd, nwr, bad);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_rdata", i), bus.rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_word", i), ram[vecs[i].addr[AW+1:2]], vecs[i].exp_word);
      check($sformatf("vec%0d_nwr", i), 32'(nwr), (vecs[i].exp_err || !vecs[i].we) ? 32'd0 : 32'd1);
      check($sformatf("vec%0d_nrd", i), 32'(nrd),
            (vecs[i].exp_err || (vecs[i].we && vecs[i].f3 == 3'd2)) ? 32'd0 : 32'd1);
      check($sformatf("vec%0d_strobes", i), 32'(bad), 32'd0);
    end

    // Random traffic against a byte-level memory model.
    for (int i = 0; i < (1 << AW); i++) begin
      v = $urandom;
      preload(AW'(i), v);
      for (int b = 0; b < 4; b++) refb[4*i+b] = v[8*b +: 8];
    end
    ref_rdata = 32'hA5A55A5A;
    f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : f3s[$urandom_range(0, 4)];
      a  = $urandom;
      d  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'd1) a[0] = 1'b0;
        if (f3 == 3'd2) a[1:0] = 2'd0;
      end
      fl   = mdl_fault(we, f3, a);
      base = int'(a[AW+1:0]);
      w    = base / 4;
      exp_rd = ref_rdata;
      if (!fl && !we) begin
        case (f3)
          3'd0: exp_rd = {{24{refb[base][7]}}, refb[base]};
          3'd4: exp_rd = {24'd0, refb[base]};
          3'd1: exp_rd = {{16{refb[base+1][7]}}, refb[base+1], refb[base]};
          3'd5: exp_rd = {16'd0, refb[base+1], refb[base]};
          default: exp_rd = ref_word(w);
        endcase
      end
      if (!fl && we) begin
        refb[base] = d[7:0];
        if (f3 != 3'd0) refb[base+1] = d[15:8];
        if (f3 == 3'd2) begin refb[base+2] = d[23:16]; refb[base+3] = d[31:24]; end
      end
      ref_rdata = exp_rd;
      run_op(we, f3, a, d, lat, e, nrd, nwr, bad);
      check($sformatf("rnd%0d_lat", i), 32'(lat),
            fl ? 32'd1 : (!we ? 32'd3 : (f3 == 3'd2 ? 32'd2 : 32'd4)));
      check($sformatf("rnd%0d_err", i), 32'(e), 32'(fl));
      check($sformatf("rnd%0d_rdata", i), bus.rdata, exp_rd);
      check($sformatf("rnd%0d_word", i), ram[w], ref_word(w));
      check($sformatf("rnd%0d_nwr", i), 32'(nwr), (!fl && we) ? 32'd1 : 32'd0);
      check($sformatf("rnd%0d_strobes", i), 32'(bad), 32'd0);
    end

    // Reset during the read phase of a read-modify-write.
    @(posedge clk); #1;
    preload(AW'(0), 32'h0BADCAFE);
    wr0 = wr_total; dn0 = done_total;
    bus.req = 1'b1; bus.we = 1'b1; bus.func3 = 3'd1; bus.addr = 32'h2; bus.wdata = 32'h1111;
    @(posedge clk); #1;
    bus.req = 1'b0;
    check("mid_rd_strobe", 32'(bus.ram_rd), 32'd1);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("mid_ready", 32'(bus.ready), 32'd1);
    check("mid_outs", 32'({bus.done, bus.err, bus.ram_ce, bus.ram_rd, bus.ram_wr}), 32'd0);
    check("mid_rdata", bus.rdata, 32'd0);
    check("mid_ram_addr", 32'(bus.ram_addr), 32'd0);
    check("mid_ram_wdata", bus.ram_wdata, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    run_op(1'b0, 3'd2, 32'h0, 32'h0, lat, e, nrd, nwr, bad);
    @(posedge clk); #1;
    check("post_lw_lat", 32'(lat), 32'd3);
    check("post_lw_err", 32'(e), 32'd0);
    check("post_lw_rdata", bus.rdata, 32'h0BADCAFE);
    check("post_word", ram[0], 32'h0BADCAFE);
    check("post_no_wr", 32'(wr_total - wr0), 32'd0);
    check("post_done_cnt", 32'(done_total - dn0), 32'd1);

    // iREQ held high with alternating SW/LW.
    for (int k = 0; k < 3; k++) hd[k] = $urandom;
    dn0 = done_total; issued = 0; ndone = 0;
    bus.req = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (bus.done) begin
        check($sformatf("held%0d_err", ndone), 32'(bus.err), 32'd0);
        if (ndone % 2 == 1) check($sformatf("held%0d_rdata", ndone), bus.rdata, hd[ndone/2]);
        ndone++;
      end
      if (bus.ready) begin
        if (issued < 6) begin
          bus.we = (issued % 2 == 0); bus.func3 = 3'd2;
          bus.addr = 32'h80 + 32'(4 * (issued / 2)); bus.wdata = hd[issued/2];
          issued++;
        end else begin
          bus.req = 1'b0;
        end
      end
      if (ndone >= 6 && !bus.req) break;
      @(posedge clk); #1;
    end
    bus.req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("held_issued", 32'(issued), 32'd6);
    check("held_ndone", 32'(ndone), 32'd6);
    check("held_done_total", 32'(done_total - dn0), 32'd6);
    for (int k = 0; k < 3; k++) check($sformatf("held_word%0d", k), ram[32 + k], hd[k]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
